// File: rtl/ds_es_pipe_if.sv
// Decode-to-execute handshake and payload bundle.
// The decode/execute neighbours drive the master side; ds_es_pipe takes the slave side.
interface ds_es_pipe_if #(
    parameter int DS_TO_ES_BUS_WD = 150,
    parameter int CNT_WD          = 32
);
    logic                       ds_valid;
    logic [DS_TO_ES_BUS_WD-1:0] ds_to_es_bus;
    logic                       loaduse;
    logic                       br_taken;
    logic                       es_ready_go;
    logic                       ms_allowin;

    logic                       ds_ready_go;
    logic                       ds_allowin;
    logic                       es_allowin;
    logic                       es_valid;
    logic                       es_to_ms_valid;
    logic [DS_TO_ES_BUS_WD-1:0] es_bus;
    logic [CNT_WD-1:0]          bubble_cnt;

    modport master (
        output ds_valid, ds_to_es_bus, loaduse, br_taken, es_ready_go, ms_allowin,
        input  ds_ready_go, ds_allowin, es_allowin, es_valid, es_to_ms_valid,
               es_bus, bubble_cnt
    );

    modport slave (
        input  ds_valid, ds_to_es_bus, loaduse, br_taken, es_ready_go, ms_allowin,
        output ds_ready_go, ds_allowin, es_allowin, es_valid, es_to_ms_valid,
               es_bus, bubble_cnt
    );
endinterface

// File: rtl/ds_es_pipe.sv
// Decode-to-execute pipeline register: load-use stall, branch flush refusal,
// bubble injection into execute and a saturating load-use bubble counter.
module ds_es_pipe #(
    parameter int DS_TO_ES_BUS_WD = 150,
    parameter int CNT_WD          = 32
) (
    input  logic        clk,
    input  logic        reset,
    ds_es_pipe_if.slave pif
);

    logic                       es_valid_q, es_valid_d;
    logic [DS_TO_ES_BUS_WD-1:0] es_bus_q,   es_bus_d;
    logic [CNT_WD-1:0]          bubble_cnt_q, bubble_cnt_d;

    logic ds_ready_go;
    logic es_allowin;
    logic move;
    logic bubble;

    assign ds_ready_go = ~pif.loaduse;
    assign es_allowin  = ~es_valid_q | (pif.es_ready_go & pif.ms_allowin);

    // A taken branch makes the decode instruction wrong-path: it neither moves
    // nor counts as a load-use bubble.
    assign move   = pif.ds_valid & ds_ready_go & es_allowin & ~pif.br_taken;
    assign bubble = es_allowin & pif.ds_valid & pif.loaduse & ~pif.br_taken;

    always_comb begin
        es_valid_d   = es_valid_q;
        es_bus_d     = es_bus_q;
        bubble_cnt_d = bubble_cnt_q;
        if (es_allowin) begin
            es_valid_d = move;
            if (move) begin
                es_bus_d = pif.ds_to_es_bus;
            end
        end
        if (bubble && (bubble_cnt_q != {CNT_WD{1'b1}})) begin
            bubble_cnt_d = bubble_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            es_valid_q   <= 1'b0;
            es_bus_q     <= '0;
            bubble_cnt_q <= '0;
        end else begin
            es_valid_q   <= es_valid_d;
            es_bus_q     <= es_bus_d;
            bubble_cnt_q <= bubble_cnt_d;
        end
    end

    assign pif.ds_ready_go    = ds_ready_go;
    assign pif.es_allowin     = es_allowin;
    assign pif.ds_allowin     = ~pif.ds_valid | (ds_ready_go & es_allowin);
    assign pif.es_valid       = es_valid_q;
    assign pif.es_to_ms_valid = es_valid_q & pif.es_ready_go;
    assign pif.es_bus         = es_bus_q;
    assign pif.bubble_cnt     = bubble_cnt_q;

endmodule
